// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD execution pipe: lane op encoding and default geometry.
package simd_pkg;

    localparam int unsigned LANES_DEF  = 8;
    localparam int unsigned LANE_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 3;
    localparam int unsigned TAG_W_DEF  = 3;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_ADDS = 3'b010,
        OP_SUBS = 3'b011,
        OP_MAX  = 3'b100,
        OP_MIN  = 3'b101,
        OP_AND  = 3'b110,
        OP_PASS = 3'b111
    } simd_op_t;

endpackage

// File: rtl/simd_exec_pipe_alu.sv
// One unsigned SIMD lane: wrapping/saturating add-sub, max/min, and, pass-through.
module simd_lane_alu
    import simd_pkg::*;
#(
    parameter int unsigned LANE_W = LANE_W_DEF
) (
    input  logic [2:0]        op_i,
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    output logic [LANE_W-1:0] result_o,
    output logic              sat_o
);

    logic [LANE_W:0] sum;
    logic [LANE_W:0] diff;

    always_comb begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        diff     = {1'b0, a_i} - {1'b0, b_i};
        result_o = '0;
        sat_o    = 1'b0;
        // Top bit of sum is the carry, top bit of diff is the borrow.
        case (simd_op_t'(op_i))
            OP_ADD:  result_o = sum[LANE_W-1:0];
            OP_SUB:  result_o = diff[LANE_W-1:0];
            OP_ADDS: begin
                if (sum[LANE_W]) begin
                    result_o = '1;
                    sat_o    = 1'b1;
                end else begin
                    result_o = sum[LANE_W-1:0];
                end
            end
            OP_SUBS: begin
                if (diff[LANE_W]) begin
                    result_o = '0;
                    sat_o    = 1'b1;
                end else begin
                    result_o = diff[LANE_W-1:0];
                end
            end
            OP_MAX:  result_o = (a_i >= b_i) ? a_i : b_i;
            OP_MIN:  result_o = (a_i <= b_i) ? a_i : b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_PASS: result_o = a_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/simd_exec_pipe.sv
// Elastic DEPTH-stage SIMD execution pipe; results computed at stage 0, later stages only carry them.
module simd_exec_pipe
    import simd_pkg::*;
#(
    parameter int unsigned LANES  = LANES_DEF,
    parameter int unsigned LANE_W = LANE_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_op,
    input  logic                      in_bcast,
    input  logic [LANES*LANE_W-1:0]   in_a,
    input  logic [LANES*LANE_W-1:0]   in_b,
    input  logic [TAG_W-1:0]          in_tag,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*LANE_W-1:0]   out_data,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      out_sat,
    output logic [(1<<TAG_W)-1:0]     pending_mask,
    output logic                      busy
);

    localparam int unsigned W = LANES * LANE_W;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] sat_q;
    logic [W-1:0]     data_q [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];

    logic [DEPTH-1:0] ready;
    logic             full_tail;
    logic [W-1:0]     alu_res;
    logic [LANES-1:0] lane_sat;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_W-1:0] b_lane;
        assign b_lane = in_bcast ? in_b[LANE_W-1:0] : in_b[i*LANE_W +: LANE_W];
        simd_lane_alu #(.LANE_W(LANE_W)) u_alu (
            .op_i     (in_op),
            .a_i      (in_a[i*LANE_W +: LANE_W]),
            .b_i      (b_lane),
            .result_o (alu_res[i*LANE_W +: LANE_W]),
            .sat_o    (lane_sat[i])
        );
    end

    // ready_k = !v_k | ready_(k+1) unrolled: stage k can move unless it and every later stage is full and the sink stalls.
    always_comb begin
        full_tail = 1'b1;
        ready     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            full_tail              = full_tail & valid_q[DEPTH-1-i];
            ready[DEPTH-1-i]       = out_ready | !full_tail;
        end
    end

    assign in_ready = ready[0] & !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            sat_q   <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            if (ready[0]) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= alu_res;
                    tag_q[0]  <= in_tag;
                    sat_q[0]  <= |lane_sat;
                end
            end
            for (int unsigned k = 1; k < DEPTH; k++) begin
                if (ready[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        data_q[k] <= data_q[k-1];
                        tag_q[k]  <= tag_q[k-1];
                        sat_q[k]  <= sat_q[k-1];
                    end
                end
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign out_tag   = tag_q[DEPTH-1];
    assign out_sat   = sat_q[DEPTH-1];
    assign busy      = |valid_q;

    always_comb begin
        pending_mask = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (valid_q[k]) pending_mask[tag_q[k]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_simd_exec_pipe.sv
// Directed self-checking bench for simd_exec_pipe at LANES=8, LANE_W=8, DEPTH=3, TAG_W=3.
module tb_simd_exec_pipe;

    localparam int unsigned LANES  = 8;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned DEPTH  = 3;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned W      = LANES * LANE_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic             in_bcast;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_sat;
    logic [7:0]       pending_mask;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    simd_exec_pipe #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_bcast     (in_bcast),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_tag       (in_tag),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_tag      (out_tag),
        .out_sat      (out_sat),
        .pending_mask (pending_mask),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic bc, input logic [63:0] a,
                        input logic [63:0] b, input logic [2:0] tag);
        in_op    = op;
        in_bcast = bc;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_bcast = 1'b0;
    endtask

    task automatic expect_beat(input string nm, input logic [2:0] tag,
                               input logic [63:0] data, input logic sat);
        int n = 0;
        while (!out_valid && n < 12) begin
            tick();
            n++;
        end
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_tag"},   64'(out_tag),   64'(tag));
        chk({nm, "_data"},  out_data,       data);
        chk({nm, "_sat"},   64'(out_sat),   64'(sat));
        tick();
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_ovalid"}, 64'(out_valid),    64'd0);
        chk({nm, "_odata"},  out_data,          64'd0);
        chk({nm, "_otag"},   64'(out_tag),      64'd0);
        chk({nm, "_osat"},   64'(out_sat),      64'd0);
        chk({nm, "_pend"},   64'(pending_mask), 64'd0);
        chk({nm, "_busy"},   64'(busy),         64'd0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        logic        sat;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int n;
        int cyc;
        int sent;
        int got;
        int seen;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'b000;
        in_bcast  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #2;
        check_idle("rst");
        chk("rst_inready", 64'(in_ready), 64'd1);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // ADD wraps, 3-cycle latency
        send(3'b000, 1'b0, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0002, 3'd2);
        n = 1;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("add_latency", 64'(n), 64'd3);
        chk("add_data", out_data, 64'h0000_0000_0000_0001);
        chk("add_sat",  64'(out_sat), 64'd0);
        chk("add_tag",  64'(out_tag), 64'd2);
        tick();

        // saturating add and subtract, back to back
        send(3'b010, 1'b0, {8{8'hF0}}, {8{8'h20}}, 3'd3);
        send(3'b011, 1'b0, {8{8'h10}}, {8{8'h20}}, 3'd4);
        expect_beat("adds", 3'd3, {8{8'hFF}}, 1'b1);
        expect_beat("subs", 3'd4, {8{8'h00}}, 1'b1);

        // broadcast MAX: other B lanes hold 0xAA so a missed broadcast shows up
        send(3'b100, 1'b1, 64'h2081_8001_FF7F_9000, 64'hAAAA_AAAA_AAAA_AA80, 3'd5);
        expect_beat("maxb", 3'd5, 64'h8081_8080_FF80_9080, 1'b0);

        tbl[0] = '{3'b001, {8{8'h01}}, {8{8'h02}}, {8{8'hFF}}, 1'b0};
        tbl[1] = '{3'b101, {8{8'h05}}, {8{8'h03}}, {8{8'h03}}, 1'b0};
        tbl[2] = '{3'b110, {8{8'hF0}}, {8{8'h3C}}, {8{8'h30}}, 1'b0};
        tbl[3] = '{3'b111, {8{8'h5A}}, {8{8'hFF}}, {8{8'h5A}}, 1'b0};
        tbl[4] = '{3'b010, {8{8'h10}}, {8{8'h20}}, {8{8'h30}}, 1'b0};
        tbl[5] = '{3'b011, {8{8'h30}}, {8{8'h10}}, {8{8'h20}}, 1'b0};
        fork
            begin
                for (int i = 0; i < 6; i++) send(tbl[i].op, 1'b0, tbl[i].a, tbl[i].b, 3'(i + 1));
            end
            begin
                for (int i = 0; i < 6; i++) expect_beat($sformatf("tbl%0d", i), 3'(i + 1), tbl[i].exp, tbl[i].sat);
            end
        join

        // backpressure: 5 beats, out_ready low in cycles 4..6
        sent = 0;
        got  = 0;
        for (cyc = 1; cyc <= 16; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 6);
            in_valid  = (sent < 5);
            in_op     = 3'b000;
            in_tag    = 3'(sent + 1);
            in_a      = {8{8'(8'h10 * (sent + 1))}};
            in_b      = {8{8'h01}};
            #1;
            if (cyc == 4) begin
                chk("bp_inready_c4", 64'(in_ready), 64'd0);
                chk("bp_pend_c4",    64'(pending_mask), 64'h0E);
            end
            if (cyc == 6) begin
                chk("bp_hold_valid", 64'(out_valid), 64'd1);
                chk("bp_hold_data",  out_data, {8{8'h11}});
                chk("bp_hold_tag",   64'(out_tag), 64'd1);
            end
            if (cyc == 9) chk("bp_pend_c9", 64'(pending_mask), 64'h38);
            if (out_valid && out_ready) begin
                chk($sformatf("bp_order%0d", got), 64'(out_tag), 64'(got + 1));
                chk($sformatf("bp_data%0d", got), out_data, {8{8'(8'h10 * (got + 1) + 1)}});
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 64'(got), 64'd5);

        // flush with three in flight and a simultaneous input beat
        send(3'b111, 1'b0, {8{8'h01}}, '0, 3'd1);
        send(3'b111, 1'b0, {8{8'h02}}, '0, 3'd2);
        send(3'b111, 1'b0, {8{8'h03}}, '0, 3'd3);
        chk("fl_busy_pre", 64'(busy), 64'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = 3'b111;
        in_a     = {8{8'h77}};
        in_tag   = 3'd7;
        #1;
        chk("fl_inready", 64'(in_ready), 64'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_ovalid", 64'(out_valid), 64'd0);
        chk("fl_busy",   64'(busy), 64'd0);
        chk("fl_pend",   64'(pending_mask), 64'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("fl_ghost", 64'(seen), 64'd0);

        // asynchronous reset between edges with a beat held at the output
        out_ready = 1'b0;
        send(3'b000, 1'b0, {8{8'h21}}, {8{8'h01}}, 3'd6);
        tick();
        tick();
        chk("ar_pre_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_idle("ar");
        chk("ar_inready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #3;
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        send(3'b000, 1'b0, {8{8'h21}}, {8{8'h01}}, 3'd6);
        n = 1;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("ar_latency", 64'(n), 64'd3);
        chk("ar_data", out_data, {8{8'h22}});
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
